control_sequencer: RTL

- T-state sequencer and instruction decoder for the 4-bit microcontroller datapath.
- Drives the 16-bit control word that the PC, MAR, RAM, IR, B register, ALU, accumulator and output register consume.
- Advances on the rising clock edge, so the control word is stable before the falling edge, where the datapath registers (accumulator included) latch.
- Instruction byte is opcode[7:4] and operand[3:0]; this block sees only the opcode plus the ALU flags.

---
 rtl/control_sequencer_if.sv | 48 ++++
 rtl/control_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer_if.sv
// -----------------------------------------------------------------------------
// control_sequencer_if
//
// Bundles the signals exchanged between the T-state sequencer and the
// 4-bit datapath it steers.
//
// Signals:
//   run         sequencing enable (datapath/front panel -> sequencer)
//   ir_opcode   opcode field of the instruction register, IR[7:4]
//   zero_flag   registered ALU zero flag
//   carry_flag  registered ALU carry flag
//   control     16-bit control word (sequencer -> datapath)
//   t_state     current T-state, 0..4, 7 while halted
//   halted      high while the sequencer sits in HALT
//
// Modports:
//   master  the sequencer side: consumes status, drives the control word
//   slave   the datapath side: drives status, consumes the control word
// -----------------------------------------------------------------------------
interface control_sequencer_if;
    logic        run;
    logic [3:0]  ir_opcode;
    logic        zero_flag;
    logic        carry_flag;
    logic [15:0] control;
    logic [2:0]  t_state;
    logic        halted;

    modport master (
        input  run,
        input  ir_opcode,
        input  zero_flag,
        input  carry_flag,
        output control,
        output t_state,
        output halted
    );

    modport slave (
        output run,
        output ir_opcode,
        output zero_flag,
        output carry_flag,
        input  control,
        input  t_state,
        input  halted
    );
endinterface

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
//
// T-state sequencer and instruction decoder for the 4-bit microcontroller.
// The state register advances on the rising edge so the control word has
// settled before the falling edge, where the datapath registers latch.
// Every instruction runs a two-state fetch (T0, T1) followed by one to three
// execute states (T2..T4). HLT parks the sequencer in HALT until reset.
//
// Parameters:
//   NUM_T_STATES  number of active T-states (T0..T4), 3-bit state encoding
//   HLT_OPCODE    opcode that enters HALT
//
// Ports:
//   clk    system clock, state advances on posedge
//   reset  asynchronous, active-high; returns to T0 and blanks the control word
//   bus    control_sequencer_if.master: run, ir_opcode, zero_flag, carry_flag
//          in; control, t_state, halted out
// -----------------------------------------------------------------------------
module control_sequencer #(
    parameter int         NUM_T_STATES = 5,
    parameter logic [3:0] HLT_OPCODE   = 4'hF
) (
    input  logic                       clk,
    input  logic                       reset,
    control_sequencer_if.master        bus
);

    // -------------------------------------------------------------------------
    // Control word bit masks
    // -------------------------------------------------------------------------
    localparam logic [15:0] CB_CLR_ACC  = 16'h8000;
    localparam logic [15:0] CB_HLT      = 16'h4000;
    localparam logic [15:0] CB_PC_INC   = 16'h2000;
    localparam logic [15:0] CB_PC_OUT   = 16'h1000;
    localparam logic [15:0] CB_MAR_LD   = 16'h0800;
    localparam logic [15:0] CB_RAM_OUT  = 16'h0400;
    localparam logic [15:0] CB_IR_LD    = 16'h0200;
    localparam logic [15:0] CB_IR_OUT   = 16'h0100;
    localparam logic [15:0] CB_ACC_LD   = 16'h0080;
    localparam logic [15:0] CB_ACC_OUT  = 16'h0040;
    localparam logic [15:0] CB_ALU_SUB  = 16'h0020;
    localparam logic [15:0] CB_ALU_OUT  = 16'h0010;
    localparam logic [15:0] CB_B_LD     = 16'h0008;
    localparam logic [15:0] CB_OUT_LD   = 16'h0004;
    localparam logic [15:0] CB_PC_LD    = 16'h0002;
    localparam logic [15:0] CB_FLAGS_LD = 16'h0001;

    // Composite words reused by several instructions
    localparam logic [15:0] CW_FETCH_ADDR = CB_PC_OUT | CB_MAR_LD;
    localparam logic [15:0] CW_FETCH_INSN = CB_RAM_OUT | CB_IR_LD | CB_PC_INC;
    localparam logic [15:0] CW_OPND_ADDR  = CB_IR_OUT | CB_MAR_LD;
    localparam logic [15:0] CW_JUMP       = CB_IR_OUT | CB_PC_LD;
    localparam logic [15:0] CW_ALU_WB     = CB_ALU_OUT | CB_ACC_LD | CB_FLAGS_LD;

    // -------------------------------------------------------------------------
    // Opcodes
    // -------------------------------------------------------------------------
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_OUT = 4'h4;
    localparam logic [3:0] OP_JMP = 4'h5;
    localparam logic [3:0] OP_JZ  = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_CLR = 4'h8;

    // -------------------------------------------------------------------------
    // State encoding: T-states are their own index so t_state is the state
    // register itself. 5 and 6 are unused and fall back to T0.
    // -------------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_T0   = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_T4   = 3'd4,
        ST_HALT = 3'd7
    } state_e;

    // Index of the final active T-state; the memory-operand instructions run
    // up to this state before returning to T0.
    localparam logic [2:0] LAST_T = 3'(NUM_T_STATES - 1);

    state_e state_q;
    state_e state_d;

    logic [15:0] control_d;
    logic        is_mem_op;
    logic        is_hlt;

    // Instructions that need the full operand-fetch/ALU path through T4.
    assign is_mem_op = (bus.ir_opcode == OP_LDA) ||
                       (bus.ir_opcode == OP_ADD) ||
                       (bus.ir_opcode == OP_SUB);

    assign is_hlt = (bus.ir_opcode == HLT_OPCODE);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_T0;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_T0: begin
                if (bus.run) begin
                    state_d = ST_T1;
                end
            end
            ST_T1: begin
                if (bus.run) begin
                    state_d = ST_T2;
                end
            end
            ST_T2: begin
                if (bus.run) begin
                    // HLT is checked first so it wins even if HLT_OPCODE is
                    // moved onto one of the other opcode values.
                    if (is_hlt) begin
                        state_d = ST_HALT;
                    end else if (is_mem_op && (LAST_T >= 3'd3)) begin
                        state_d = ST_T3;
                    end else begin
                        state_d = ST_T0;
                    end
                end
            end
            ST_T3: begin
                if (bus.run) begin
                    state_d = (LAST_T >= 3'd4) ? ST_T4 : ST_T0;
                end
            end
            ST_T4: begin
                if (bus.run) begin
                    state_d = ST_T0;
                end
            end
            ST_HALT: begin
                // Only reset leaves HALT; run is deliberately ignored.
                state_d = ST_HALT;
            end
            default: begin
                // Unused encodings recover unconditionally.
                state_d = ST_T0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Control word decode. Blanked during reset and while run is low so a
    // frozen state never repeats a side effect such as PC_INC.
    // -------------------------------------------------------------------------
    always_comb begin
        control_d = 16'h0000;
        if (!reset && bus.run) begin
            case (state_q)
                ST_T0: control_d = CW_FETCH_ADDR;
                ST_T1: control_d = CW_FETCH_INSN;
                ST_T2: begin
                    if (is_hlt) begin
                        control_d = CB_HLT;
                    end else begin
                        case (bus.ir_opcode)
                            OP_NOP: control_d = 16'h0000;
                            OP_LDA,
                            OP_ADD,
                            OP_SUB: control_d = CW_OPND_ADDR;
                            OP_OUT: control_d = CB_ACC_OUT | CB_OUT_LD;
                            OP_JMP: control_d = CW_JUMP;
                            // Flags are only looked at here, combinationally,
                            // so a late flag change still takes effect.
                            OP_JZ:  control_d = bus.zero_flag  ? CW_JUMP : 16'h0000;
                            OP_JC:  control_d = bus.carry_flag ? CW_JUMP : 16'h0000;
                            OP_CLR: control_d = CB_CLR_ACC | CB_FLAGS_LD;
                            default: control_d = 16'h0000;
                        endcase
                    end
                end
                ST_T3: begin
                    case (bus.ir_opcode)
                        // LDA clears the accumulator so the ALU add in T4
                        // yields 0 + B, i.e. a plain load.
                        OP_LDA:  control_d = CB_RAM_OUT | CB_B_LD | CB_CLR_ACC;
                        OP_ADD,
                        OP_SUB:  control_d = CB_RAM_OUT | CB_B_LD;
                        default: control_d = 16'h0000;
                    endcase
                end
                ST_T4: begin
                    case (bus.ir_opcode)
                        OP_LDA,
                        OP_ADD:  control_d = CW_ALU_WB;
                        OP_SUB:  control_d = CW_ALU_WB | CB_ALU_SUB;
                        default: control_d = 16'h0000;
                    endcase
                end
                default: control_d = 16'h0000;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.control = control_d;
    assign bus.t_state = state_q;
    assign bus.halted  = (state_q == ST_HALT);

endmodule
